// File: rtl/dcache_flush_walker_if.sv
// Tag-array access and miss-unit write-back channels used by the dcache flush walker.
// The walker drives the master side; the tag array and miss unit sit on the slave side.
interface dcache_flush_walker_if #(
   parameter int NUM_SETS = 256,
   parameter int NUM_WAYS = 8,
   parameter int TAG_W    = 44,
   parameter int OFFSET_W = 4
);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int PLEN  = TAG_W + SET_W + OFFSET_W;

   logic             tag_req;
   logic             tag_gnt;
   logic             tag_we;
   logic [SET_W-1:0] tag_set;
   logic [WAY_W-1:0] tag_way;
   logic             tag_valid;
   logic             tag_dirty;
   logic [TAG_W-1:0] tag;

   logic             wb_valid;
   logic             wb_ready;
   logic [PLEN-1:0]  wb_addr;
   logic [WAY_W-1:0] wb_way;
   logic             wb_done;

   modport master (
      output tag_req, tag_we, tag_set, tag_way,
      input  tag_gnt, tag_valid, tag_dirty, tag,
      output wb_valid, wb_addr, wb_way,
      input  wb_ready, wb_done
   );

   modport slave (
      input  tag_req, tag_we, tag_set, tag_way,
      output tag_gnt, tag_valid, tag_dirty, tag,
      input  wb_valid, wb_addr, wb_way,
      output wb_ready, wb_done
   );
endinterface

// File: rtl/dcache_flush_walker.sv
// Write-back dcache flush engine: walks every set/way, writes back dirty lines, invalidates valid ones.
// Optional feature macro DCACHE_FLUSH_PERF_CNT_EN adds wb_count_o (write-backs in current/last flush).
module dcache_flush_walker #(
   parameter int NUM_SETS = 256,
   parameter int NUM_WAYS = 8,
   parameter int TAG_W    = 44,
   parameter int OFFSET_W = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic flush_i,
   output logic flush_ack_o,
   output logic busy_o,
   dcache_flush_walker_if.master bus
`ifdef DCACHE_FLUSH_PERF_CNT_EN
   ,
   output logic [31:0] wb_count_o
`endif
);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CHECK,
      S_WB,
      S_WB_WAIT,
      S_INV,
      S_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [SET_W-1:0] set_reg, set_next;
   logic [WAY_W-1:0] way_reg, way_next;
   logic [TAG_W-1:0] tag_reg, tag_next;
   logic             advance;

   // clr_i is a synchronous twin of rst_i: same clean slate, one cycle later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= S_IDLE;
         set_reg   <= '0;
         way_reg   <= '0;
         tag_reg   <= '0;
      end else if (clr_i) begin
         state_reg <= S_IDLE;
         set_reg   <= '0;
         way_reg   <= '0;
         tag_reg   <= '0;
      end else begin
         state_reg <= state_next;
         set_reg   <= set_next;
         way_reg   <= way_next;
         tag_reg   <= tag_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      set_next     = set_reg;
      way_next     = way_reg;
      tag_next     = tag_reg;
      advance      = 1'b0;
      flush_ack_o  = 1'b0;
      busy_o       = (state_reg != S_IDLE);
      bus.tag_req  = 1'b0;
      bus.tag_we   = 1'b0;
      bus.tag_set  = set_reg;
      bus.tag_way  = way_reg;
      bus.wb_valid = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_way   = '0;

      case (state_reg)
         S_IDLE: begin
            if (flush_i) begin
               state_next = S_READ;
               set_next   = '0;
               way_next   = '0;
            end
         end
         S_READ: begin
            bus.tag_req = 1'b1;
            if (bus.tag_gnt) begin
               state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            // Read data arrives the cycle after the grant; keep the tag for the write-back address.
            tag_next = bus.tag;
            if (bus.tag_valid && bus.tag_dirty) begin
               state_next = S_WB;
            end else if (bus.tag_valid) begin
               state_next = S_INV;
            end else begin
               advance = 1'b1;
            end
         end
         S_WB: begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = {tag_reg, set_reg, {OFFSET_W{1'b0}}};
            bus.wb_way   = way_reg;
            if (bus.wb_ready) begin
               state_next = bus.wb_done ? S_INV : S_WB_WAIT;
            end
         end
         S_WB_WAIT: begin
            if (bus.wb_done) begin
               state_next = S_INV;
            end
         end
         S_INV: begin
            bus.tag_req = 1'b1;
            bus.tag_we  = 1'b1;
            if (bus.tag_gnt) begin
               advance = 1'b1;
            end
         end
         S_DONE: begin
            flush_ack_o = 1'b1;
            state_next  = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Set-major, way-minor walk; stepping past the final entry ends the flush.
      if (advance) begin
         if (way_reg == LAST_WAY) begin
            way_next = '0;
            set_next = set_reg + SET_W'(1);
         end else begin
            way_next = way_reg + WAY_W'(1);
         end
         state_next = ((set_reg == LAST_SET) && (way_reg == LAST_WAY)) ? S_DONE : S_READ;
      end
   end

`ifdef DCACHE_FLUSH_PERF_CNT_EN
   logic [31:0] wb_count_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_count_reg <= '0;
      end else if (clr_i) begin
         wb_count_reg <= '0;
      end else if ((state_reg == S_IDLE) && flush_i) begin
         wb_count_reg <= '0;
      end else if (bus.wb_valid && bus.wb_ready && (wb_count_reg != 32'hFFFF_FFFF)) begin
         wb_count_reg <= wb_count_reg + 32'd1;
      end
   end

   assign wb_count_o = wb_count_reg;
`endif
endmodule

// File: tb/tb_dcache_flush_walker.sv
// Directed bench for dcache_flush_walker on a 4-set, 2-way cache with a behavioural tag array and miss unit.
`timescale 1ns/1ps
module tb_dcache_flush_walker;
   localparam int NUM_SETS = 4;
   localparam int NUM_WAYS = 2;
   localparam int TAG_W    = 44;
   localparam int OFFSET_W = 4;
   localparam int PLEN     = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic flush = 1'b0;
   logic flush_ack;
   logic busy;
`ifdef DCACHE_FLUSH_PERF_CNT_EN
   logic [31:0] wb_count;
`endif

   dcache_flush_walker_if #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)) bus ();

   dcache_flush_walker #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clr_i       (clr),
      .flush_i     (flush),
      .flush_ack_o (flush_ack),
      .busy_o      (busy),
      .bus         (bus)
`ifdef DCACHE_FLUSH_PERF_CNT_EN
      ,
      .wb_count_o  (wb_count)
`endif
   );

   always #5 clk = ~clk;

   // Tag array contents, loaded directly by the stimulus before each flush.
   bit          mem_valid [8];
   bit          mem_dirty [8];
   logic [43:0] mem_tag   [8];

   logic [2:0]      inv_q[$];
   logic [2:0]      rd_q[$];
   logic [PLEN-1:0] wb_addr_q[$];
   logic [0:0]      wb_way_q[$];
   int              ack_total = 0;
   int              cyc = 0;
   int              done_mode = 0;
   int              done_cnt = 0;
   logic [2:0]      cur_idx;

   assign cur_idx = {bus.tag_set, bus.tag_way};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.tag_req && bus.tag_gnt && !bus.tag_we) begin
         bus.tag_valid <= mem_valid[cur_idx];
         bus.tag_dirty <= mem_dirty[cur_idx];
         bus.tag       <= mem_tag[cur_idx];
         rd_q.push_back(cur_idx);
      end else begin
         bus.tag_valid <= 1'b0;
         bus.tag_dirty <= 1'b0;
         bus.tag       <= '0;
      end
      if (bus.tag_req && bus.tag_gnt && bus.tag_we) inv_q.push_back(cur_idx);
      if (bus.wb_valid && bus.wb_ready) begin
         wb_addr_q.push_back(bus.wb_addr);
         wb_way_q.push_back(bus.wb_way);
      end
      if (flush_ack) ack_total <= ack_total + 1;
   end

   // Miss unit completion: 0 = done with the handshake, 1 = done 3 cycles later, 2 = never.
   always @(posedge clk) begin
      if (done_mode == 0) begin
         bus.wb_done <= 1'b1;
      end else if (done_mode == 1) begin
         if (bus.wb_valid && bus.wb_ready) begin
            done_cnt    <= 3;
            bus.wb_done <= 1'b0;
         end else if (done_cnt > 0) begin
            done_cnt    <= done_cnt - 1;
            bus.wb_done <= (done_cnt == 2);
         end else begin
            bus.wb_done <= 1'b0;
         end
      end else begin
         bus.wb_done <= 1'b0;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 8; i++) begin
         mem_valid[i] = 1'b0;
         mem_dirty[i] = 1'b0;
         mem_tag[i]   = '0;
      end
   endtask

   task automatic set_line(input int idx, input bit v, input bit d, input logic [43:0] t);
      mem_valid[idx] = v;
      mem_dirty[idx] = d;
      mem_tag[idx]   = t;
   endtask

   // One flush transaction; optional grant/ready stalls check that the held request stays put.
   task automatic run_flush(input string name, input int gnt_stall, input int rdy_stall,
                            input logic [PLEN-1:0] hold_addr,
                            output int lat, output int acks, output int busy_n);
      int  start;
      int  seen_g;
      int  seen_r;
      int  post;
      bit  got;
      @(negedge clk);
      if (gnt_stall > 0) bus.tag_gnt = 1'b0;
      if (rdy_stall > 0) bus.wb_ready = 1'b0;
      flush = 1'b1;
      start = cyc;
      lat = -1; acks = 0; busy_n = 0; got = 0; post = 0; seen_g = 0; seen_r = 0;
      for (int i = 0; i < 300 && post < 4; i++) begin
         @(negedge clk);
         busy_n += int'(busy);
         if (flush_ack) begin
            acks++;
            if (!got) begin
               got = 1;
               lat = cyc - start;
               flush = 1'b0;
            end
         end
         if (got) post++;
         if (!bus.tag_gnt && bus.tag_req) begin
            if (seen_g == gnt_stall) bus.tag_gnt = 1'b1;
            else begin
               check_val("gnt_hold_req", {61'd0, bus.tag_we, bus.tag_set}, 0);
               seen_g++;
            end
         end
         if (!bus.wb_ready && bus.wb_valid) begin
            if (seen_r == rdy_stall) bus.wb_ready = 1'b1;
            else begin
               check_val("rdy_hold_addr", bus.wb_addr, hold_addr);
               seen_r++;
            end
         end
      end
      flush = 1'b0;
      bus.tag_gnt = 1'b1;
      bus.wb_ready = 1'b1;
      $display("flush %s: latency %0d, acks %0d, busy cycles %0d", name, lat, acks, busy_n);
   endtask

   initial begin
      int lat, acks, bn, ib, wb_b, rb, ak;
      bit hs;
      bus.tag_gnt  = 1'b1;
      bus.wb_ready = 1'b1;
      clear_mem();
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_ack", flush_ack, 0);
      check_val("rst_tag_req", bus.tag_req, 0);
      check_val("rst_wb_valid", bus.wb_valid, 0);
      check_val("rst_set_way", cur_idx, 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("idle_busy", busy, 0);

      // Empty cache
      ib = inv_q.size(); wb_b = wb_addr_q.size(); rb = rd_q.size();
      run_flush("empty", 0, 0, '0, lat, acks, bn);
      check_val("empty_lat", lat, 17);
      check_val("empty_acks", acks, 1);
      check_val("empty_busy", bn, 17);
      check_val("empty_inv", inv_q.size() - ib, 0);
      check_val("empty_wb", wb_addr_q.size() - wb_b, 0);
      check_val("empty_reads", rd_q.size() - rb, 8);

      // All valid-clean: 8 invalidates in set-major order
      for (int i = 0; i < 8; i++) set_line(i, 1'b1, 1'b0, 44'h100 + 44'(i));
      ib = inv_q.size(); wb_b = wb_addr_q.size();
      run_flush("clean", 0, 0, '0, lat, acks, bn);
      check_val("clean_lat", lat, 25);
      check_val("clean_inv", inv_q.size() - ib, 8);
      check_val("clean_wb", wb_addr_q.size() - wb_b, 0);
      for (int i = 0; i < 8 && ib + i < inv_q.size(); i++) check_val("clean_order", inv_q[ib + i], i);

      // Set 2 way 1 dirty, tag 0x5
      clear_mem();
      set_line(5, 1'b1, 1'b1, 44'h5);
      ib = inv_q.size(); wb_b = wb_addr_q.size();
      run_flush("dirty", 0, 0, '0, lat, acks, bn);
      check_val("dirty_lat", lat, 19);
      check_val("dirty_wb_n", wb_addr_q.size() - wb_b, 1);
      if (wb_addr_q.size() > wb_b) begin
         check_val("dirty_wb_addr", wb_addr_q[wb_b], 64'h160);
         check_val("dirty_wb_way", wb_way_q[wb_b], 1);
      end
      check_val("dirty_inv_n", inv_q.size() - ib, 1);
      if (inv_q.size() > ib) check_val("dirty_inv_idx", inv_q[ib], 5);

      // Same line, wb_done three cycles after the handshake
      done_mode = 1;
      run_flush("dirty_slow", 0, 0, '0, lat, acks, bn);
      check_val("slow_lat", lat, 22);
      check_val("slow_acks", acks, 1);
      done_mode = 0;

      // Grant stalled 5 cycles on the first read, ready stalled 4 cycles
      ib = inv_q.size(); wb_b = wb_addr_q.size();
      run_flush("stall", 5, 4, 50'h160, lat, acks, bn);
      check_val("stall_lat", lat, 28);
      check_val("stall_wb_n", wb_addr_q.size() - wb_b, 1);
      check_val("stall_inv_n", inv_q.size() - ib, 1);

      // Reset while waiting for wb_done
      done_mode = 2;
      clear_mem();
      set_line(0, 1'b1, 1'b1, 44'hABC);
      ak = ack_total; wb_b = wb_addr_q.size();
      @(negedge clk);
      flush = 1'b1;
      hs = 0;
      for (int i = 0; i < 50 && !hs; i++) begin
         @(negedge clk);
         if (bus.wb_valid && bus.wb_ready) hs = 1;
      end
      check_val("rst_reach_wb", hs, 1);
      @(negedge clk);
      flush = 1'b0;
      check_val("wbwait_state", {busy, bus.wb_valid}, 2'b10);
      rst = 1'b1;
      #1;
      check_val("async_busy", busy, 0);
      check_val("async_req", {bus.tag_req, bus.tag_we, bus.wb_valid, flush_ack}, 0);
      check_val("async_addr", bus.wb_addr, 0);
      check_val("async_set_way", {bus.wb_way, cur_idx}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_val("rst_no_ack", ack_total - ak, 0);
      check_val("rst_no_wb", wb_addr_q.size() - wb_b, 1);
      check_val("rst_idle", busy, 0);
      done_mode = 0;
      rb = rd_q.size(); wb_b = wb_addr_q.size();
      run_flush("after_rst", 0, 0, '0, lat, acks, bn);
      check_val("rerun_lat", lat, 19);
      if (rd_q.size() > rb) check_val("rerun_first_rd", rd_q[rb], 0);
      if (wb_addr_q.size() > wb_b) check_val("rerun_wb_addr", wb_addr_q[wb_b], 64'h2AF00);

      // Synchronous clear mid-walk
      for (int i = 0; i < 8; i++) set_line(i, 1'b1, 1'b0, 44'h7);
      ak = ack_total;
      @(negedge clk);
      flush = 1'b1;
      repeat (6) @(negedge clk);
      check_val("clr_busy_before", busy, 1);
      flush = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check_val("clr_idle", {busy, bus.tag_req}, 0);
      repeat (5) @(negedge clk);
      check_val("clr_no_ack", ack_total - ak, 0);

      // Three dirty lines
      clear_mem();
      set_line(1, 1'b1, 1'b1, 44'h11);
      set_line(4, 1'b1, 1'b1, 44'h22);
      set_line(7, 1'b1, 1'b1, 44'h33);
      wb_b = wb_addr_q.size();
      run_flush("three_dirty", 0, 0, '0, lat, acks, bn);
      check_val("three_lat", lat, 23);
      check_val("three_wb_n", wb_addr_q.size() - wb_b, 3);
      if (wb_addr_q.size() >= wb_b + 3) begin
         check_val("three_addr0", wb_addr_q[wb_b], 64'h440);
         check_val("three_addr1", wb_addr_q[wb_b + 1], 64'h8A0);
         check_val("three_addr2", wb_addr_q[wb_b + 2], 64'hCF0);
         check_val("three_ways", {wb_way_q[wb_b], wb_way_q[wb_b + 1], wb_way_q[wb_b + 2]}, 3'b101);
      end
`ifdef DCACHE_FLUSH_PERF_CNT_EN
      check_val("perf_count", wb_count, 3);
      clear_mem();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      check_val("perf_cleared", wb_count, 0);
      flush = 1'b0;
      repeat (25) @(negedge clk);
      check_val("perf_empty", wb_count, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
